// File: rtl/mem_port_arbiter_if.sv
// Fetch/data request ports and single-port RAM bus shared by the arbiter.
// slave: arbiter side; master: requester/RAM side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_gnt_o;
  logic              dm_rvalid_o;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM between fetch and data ports.
// Ports: clk, reset (async, active-high), bus (slave modport).
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] IF_RD = 2'd1;
  localparam logic [1:0] DM_RD = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [CW-1:0]     r_starve;
  logic [DATA_W-1:0] r_if_hold;
  logic              w_force;
  logic              w_if_gnt;
  logic              w_dm_gnt;
  logic              w_if_rv;
  logic              w_dm_rv;

  // fetch wins only once it has been denied STARVE_MAX cycles
  assign w_force  = bus.if_req_i & (r_starve == SMAX);
  assign w_dm_gnt = bus.dm_req_i & ~w_force;
  assign w_if_gnt = bus.if_req_i
                  & (~bus.dm_req_i | w_force);

  assign bus.if_gnt_o = w_if_gnt;
  assign bus.dm_gnt_o = w_dm_gnt;

  assign bus.mem_en_o = w_if_gnt | w_dm_gnt;
  assign bus.mem_we_o = w_dm_gnt & bus.dm_we_i;
  assign bus.mem_addr_o =
    w_if_gnt ? bus.if_addr_i :
    w_dm_gnt ? bus.dm_addr_i : '0;
  assign bus.mem_wdata_o =
    w_dm_gnt ? bus.dm_wdata_i : '0;

  always_comb begin
    w_next = IDLE;
    unique case (1'b1)
      w_if_gnt:                  w_next = IF_RD;
      w_dm_gnt & ~bus.dm_we_i:   w_next = DM_RD;
      default:                   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
    end else if (bus.if_req_i & ~w_if_gnt) begin
      if (r_starve != SMAX) r_starve <= r_starve + 1'b1;
    end else begin
      r_starve <= '0;
    end
  end

  assign w_if_rv = (r_state == IF_RD);
  assign w_dm_rv = (r_state == DM_RD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_if_hold <= '0;
    end else if (w_if_rv) begin
      r_if_hold <= bus.mem_rdata_i;
    end
  end

  assign bus.if_rvalid_o = w_if_rv;
  assign bus.dm_rvalid_o = w_dm_rv;
  assign bus.if_rdata_o =
    w_if_rv ? bus.mem_rdata_i : r_if_hold;
  assign bus.dm_rdata_o =
    w_dm_rv ? bus.mem_rdata_i : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of mem_port_arbiter
// against a cycle-level behavioural model.
module tb_mem_port_arbiter;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [31:0] ram [16];

  always @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 16; n++) ram[n] <= 32'h100 + n;
      ram[8] <= 32'hDEAD;
    end else if (bus.mem_en_o) begin
      if (bus.mem_we_o) ram[bus.mem_addr_o[3:0]] <= bus.mem_wdata_o;
      else bus.mem_rdata_i <= ram[bus.mem_addr_o[3:0]];
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  logic [31:0] rmem [16];
  int          ms;
  int          pend;
  logic [31:0] pdata;
  logic [31:0] hold;
  logic        g_if, g_dm;

  task automatic model_reset();
    for (int n = 0; n < 16; n++) rmem[n] = 32'h100 + n;
    rmem[8] = 32'hDEAD;
    ms = 0; pend = 0; hold = 0; pdata = 0;
  endtask

  task automatic cyc(input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] dd);
    bit frc, ig, dg;
    @(negedge clk);
    bus.if_req_i = ir; bus.if_addr_i = ia;
    bus.dm_req_i = dr; bus.dm_we_i = dw;
    bus.dm_addr_i = da; bus.dm_wdata_i = dd;
    #1;
    frc = ir && (ms == SM);
    dg  = dr && !frc;
    ig  = ir && (!dr || frc);
    g_if = bus.if_gnt_o;
    g_dm = bus.dm_gnt_o;
    chk("if_gnt", bus.if_gnt_o, ig);
    chk("dm_gnt", bus.dm_gnt_o, dg);
    chk("mem_en", bus.mem_en_o, ig || dg);
    chk("mem_we", bus.mem_we_o, dg && dw);
    chk("mem_addr", bus.mem_addr_o, ig ? ia : dg ? da : 0);
    chk("mem_wdata", bus.mem_wdata_o, dg ? dd : 0);
    chk("if_rvalid", bus.if_rvalid_o, pend == 1);
    chk("dm_rvalid", bus.dm_rvalid_o, pend == 2);
    chk("dm_rdata", bus.dm_rdata_o, (pend == 2) ? pdata : 0);
    chk("if_rdata", bus.if_rdata_o, (pend == 1) ? pdata : hold);
    if (pend == 1) hold = pdata;
    if (ig) begin
      pend = 1; pdata = rmem[ia[3:0]];
    end else if (dg && !dw) begin
      pend = 2; pdata = rmem[da[3:0]];
    end else begin
      pend = 0;
    end
    if (dg && dw) rmem[da[3:0]] = dd;
    if (ig || !ir) ms = 0;
    else if (ms < SM) ms++;
  endtask

  task automatic idle_inputs();
    bus.if_req_i = 0; bus.if_addr_i = 0;
    bus.dm_req_i = 0; bus.dm_we_i = 0;
    bus.dm_addr_i = 0; bus.dm_wdata_i = 0;
  endtask

  logic        ir, dr, dw;
  logic [31:0] ia, da, dd;

  initial begin
    idle_inputs();
    bus.mem_rdata_i = 32'h0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_rvalid", bus.if_rvalid_o, 0);
    chk("rst_dm_rvalid", bus.dm_rvalid_o, 0);
    chk("rst_if_rdata", bus.if_rdata_o, 0);
    chk("rst_dm_rdata", bus.dm_rdata_o, 0);
    chk("rst_mem_en", bus.mem_en_o, 0);
    @(negedge clk);
    reset = 1'b0;

    // solo fetch
    for (int i = 0; i < 3; i++) cyc(1, i, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("solo_last", bus.if_rdata_o, 32'h102);
    // collision: data wins, fetch word held
    cyc(1, 3, 1, 0, 8, 0);
    cyc(1, 3, 0, 0, 0, 0);
    chk("coll_dm", bus.dm_rdata_o, 32'hDEAD);
    chk("coll_hold", bus.if_rdata_o, 32'h102);
    cyc(0, 0, 0, 0, 0, 0);
    // starvation
    for (int i = 0; i < 6; i++) begin
      cyc(1, 2, 1, 0, 8, 0);
      chk("starve_if", g_if, i == 4);
      chk("starve_dm", g_dm, i != 4);
    end
    cyc(0, 0, 0, 0, 0, 0);
    // store then load
    cyc(0, 0, 1, 1, 3, 32'h55);
    cyc(0, 0, 1, 0, 3, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("st_ld", bus.dm_rdata_o, 32'h55);
    // interleave
    cyc(0, 0, 1, 0, 8, 0);
    cyc(1, 4, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("ilv_if", bus.if_rdata_o, 32'h104);

    // reset mid-read
    cyc(1, 5, 0, 0, 0, 0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("rmid_if_rvalid", bus.if_rvalid_o, 0);
    chk("rmid_if_rdata", bus.if_rdata_o, 0);
    chk("rmid_starve", dut.r_starve, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // random traffic with held-until-granted requests
    ir = 0; dr = 0; dw = 0; ia = 0; da = 0; dd = 0;
    for (int i = 0; i < 600; i++) begin
      if (!(ir && !g_if) || i == 0) begin
        ir = ($urandom_range(0, 3) != 0);
        ia = $urandom_range(0, 15);
      end
      if (!(dr && !g_dm) || i == 0) begin
        dr = ($urandom_range(0, 3) != 0);
        dw = $urandom_range(0, 1);
        da = $urandom_range(0, 15);
        dd = $urandom;
      end
      cyc(ir, ia, dr, dw, da, dd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported synchronous RAM between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline. Per cycle, grants at most one requester. Data accesses win by default; a starvation counter guarantees fetch forward progress. Tracks which requester owns the 1-cycle-latency read response. Holds the last fetched instruction so a stalled fetch stage sees a stable word.

## Interface

- Parameters:
  - `ADDR_W`, default 32: word address width.
  - `DATA_W`, default 32: data/instruction width.
  - `STARVE_MAX`, default 4: consecutive denied fetch cycles before fetch is forced to win; legal range ≥1.
- Clock and reset (already decided): one clock, `clk`; reset `reset`, asynchronous, active-high.
- Ports (name, direction, width, meaning):
  - `clk`, in, 1: clock; all state updates on the rising edge.
  - `reset`, in, 1: asynchronous active-high reset.
  - `if_req_i`, in, 1: fetch read request.
  - `if_addr_i`, in, ADDR_W: fetch word address.
  - `if_gnt_o`, out, 1: fetch request accepted this cycle; the pipeline stalls fetch when `if_req_i & ~if_gnt_o`.
  - `if_rvalid_o`, out, 1: instruction data valid this cycle.
  - `if_rdata_o`, out, DATA_W: instruction word.
  - `dm_req_i`, in, 1: data access request.
  - `dm_we_i`, in, 1: 1 = store, 0 = load.
  - `dm_addr_i`, in, ADDR_W: data word address.
  - `dm_wdata_i`, in, DATA_W: store data.
  - `dm_gnt_o`, out, 1: data request accepted this cycle.
  - `dm_rvalid_o`, out, 1: load data valid this cycle.
  - `dm_rdata_o`, out, DATA_W: load data.
  - `mem_en_o`, out, 1: RAM access enable.
  - `mem_we_o`, out, 1: RAM write enable.
  - `mem_addr_o`, out, ADDR_W: RAM address.
  - `mem_wdata_o`, out, DATA_W: RAM write data.
  - `mem_rdata_i`, in, DATA_W: RAM read data, valid the cycle after an enabled read.

## Operation

- **Grant logic** (combinational from requests and the starve counter):
  - `force_if = if_req_i & (starve_cnt == STARVE_MAX)`.
  - `dm_gnt_o = dm_req_i & ~force_if`.
  - `if_gnt_o = if_req_i & (~dm_req_i | force_if)`.
  - Never both high.
- **RAM mux:**
  - `mem_en_o = if_gnt_o | dm_gnt_o`.
  - `mem_we_o = dm_gnt_o & dm_we_i`.
  - Address comes from the granted port; 0 when idle.
  - `mem_wdata_o = dm_wdata_i` whenever `dm_gnt_o`, else 0.
- **Starve counter:** width `$clog2(STARVE_MAX+1)`.
  - Increments when `if_req_i & ~if_gnt_o`, saturating at `STARVE_MAX`.
  - Clears to 0 when `if_gnt_o` or `~if_req_i`.
- **Response FSM:** states `IDLE`, `IF_RD`, `DM_RD`. The next state is set every cycle from that cycle's grants:
  - `if_gnt_o` → `IF_RD`.
  - `dm_gnt_o & ~dm_we_i` → `DM_RD`.
  - Otherwise (including a store) → `IDLE`.
  - Back-to-back grants chain directly, e.g. `IF_RD` → `DM_RD`, with no idle cycle.
- **Read responses:**
  - `if_rvalid_o = (state == IF_RD)` and `dm_rvalid_o = (state == DM_RD)`; both are decoded from registered state.
  - `dm_rdata_o = mem_rdata_i` when `dm_rvalid_o`, else 0.
  - `if_rdata_o = mem_rdata_i` when `if_rvalid_o`, else `if_hold`.
  - `if_hold` register loads `mem_rdata_i` on each `IF_RD` cycle.
- **Stores:** complete in the grant cycle; no response.
- **Simultaneous requests:** data port wins unless `force_if`. While `force_if`, `dm_req_i` sees `dm_gnt_o = 0` and must stay asserted with stable address and data until granted.

## Timing

- Grant latency: 0 cycles (same cycle as request).
- Read latency: rvalid and data exactly 1 cycle after the grant cycle.
- Throughput: 1 access per cycle, with no bubbles between requesters.
- Worst-case fetch wait under continuous data traffic: `STARVE_MAX` cycles; grant arrives in cycle `STARVE_MAX+1`.
- Reset values:
  - FSM = `IDLE`; `starve_cnt` = 0; `if_hold` = 0.
  - `if_rvalid_o` = `dm_rvalid_o` = 0; `if_rdata_o` = `dm_rdata_o` = 0.
  - Grants and `mem_*` outputs follow the combinational rules (0 when no request).
- Reset asserted mid-operation: a pending response is discarded. No rvalid follows, even if the RAM returns data in the next cycle.
- Requesters must not change `*_addr_i` / `dm_we_i` / `dm_wdata_i` while a request is held and not yet granted.

## Test plan

- **Solo fetch:** `if_req_i` = 1 with addresses 0, 1, 2 on consecutive cycles, RAM preloaded `mem[n] = 0x100+n` → `if_gnt_o` = 1 every cycle; `if_rvalid_o` = 1 from cycle 2; `if_rdata_o` = 0x100, 0x101, 0x102.
- **Collision:** `if_req_i` and a `dm` load at addr 8 (`mem[8]` = 0xDEAD) in the same cycle → `dm_gnt_o` = 1, `if_gnt_o` = 0. Next cycle `dm_rvalid_o` = 1, `dm_rdata_o` = 0xDEAD, and `if_rdata_o` still holds the previous instruction.
- **Starvation:** `STARVE_MAX` = 4; `dm_req_i` and `if_req_i` held high for 6 cycles → `dm_gnt_o` high in cycles 1–4, `if_gnt_o` high in cycle 5 (`dm_gnt_o` = 0), `dm_gnt_o` high again in cycle 6 with the counter back at 0.
- **Store then load:** store 0x55 to addr 3, then load addr 3 → `mem_we_o` = 1 only in the store cycle, no rvalid for the store; `dm_rvalid_o` = 1 with 0x55 the cycle after the load grant.
- **Reset mid-read:** grant a fetch read, assert `reset` in the next cycle → `if_rvalid_o` = 0, `if_rdata_o` = 0, `starve_cnt` = 0. After release, no stale rvalid.
- **Interleave:** `dm` load at cycle 0 and fetch granted at cycle 1 → `dm_rvalid_o` at cycle 1 and `if_rvalid_o` at cycle 2, with no idle cycle and correct data routing.
